eth_idma_desc_arb: RTL and testbench

ETH_IDMA_DESC_ARB -- requirements
Module: eth_idma_desc_arb

---
 rtl/eth_idma_desc_arb.sv | 212 +++++++++++++++++++++
 tb/tb_eth_idma_desc_arb.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_idma_desc_arb.sv
// Per-channel descriptor FIFOs feeding a round-robin arbiter that issues requests to a
// DMA backend. Responses return in order and are matched to their channel through a tag FIFO.
// Each channel keeps a completion counter, a completion interrupt and a sticky error flag.
module eth_idma_desc_arb #(
    parameter int unsigned NumChan     = 2,
    parameter int unsigned DescDepth   = 4,
    parameter int unsigned MaxInFlight = 4,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned LenWidth    = 32,
    parameter int unsigned CntWidth    = 8,
    localparam int unsigned ChanW      = (NumChan > 1) ? $clog2(NumChan) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumChan-1:0]            desc_valid_i,
    output logic [NumChan-1:0]            desc_ready_o,
    input  logic [NumChan*AddrWidth-1:0]  desc_src_i,
    input  logic [NumChan*AddrWidth-1:0]  desc_dst_i,
    input  logic [NumChan*LenWidth-1:0]   desc_len_i,
    output logic                          req_valid_o,
    input  logic                          req_ready_i,
    output logic [AddrWidth-1:0]          req_src_o,
    output logic [AddrWidth-1:0]          req_dst_o,
    output logic [LenWidth-1:0]           req_len_o,
    output logic [ChanW-1:0]              req_chan_o,
    input  logic                          rsp_valid_i,
    output logic                          rsp_ready_o,
    input  logic                          rsp_error_i,
    output logic [NumChan*CntWidth-1:0]   done_cnt_o,
    output logic [NumChan-1:0]            irq_o,
    input  logic [NumChan-1:0]            irq_clr_i,
    output logic [NumChan-1:0]            err_o,
    input  logic [NumChan-1:0]            err_clr_i,
    output logic [NumChan-1:0]            busy_o
);

    localparam int unsigned PtrW    = $clog2(DescDepth);
    localparam int unsigned TagPtrW = (MaxInFlight > 1) ? $clog2(MaxInFlight) : 1;
    localparam int unsigned InfW    = $clog2(MaxInFlight + 1);

    // Descriptor FIFO storage and pointers
    logic [AddrWidth-1:0] src_mem [NumChan][DescDepth];
    logic [AddrWidth-1:0] dst_mem [NumChan][DescDepth];
    logic [LenWidth-1:0]  len_mem [NumChan][DescDepth];
    logic [PtrW-1:0]      wptr_q  [NumChan];
    logic [PtrW-1:0]      rptr_q  [NumChan];
    logic [PtrW:0]        cnt_q   [NumChan];

    logic [NumChan-1:0] full, nonempty, accept, len_zero, push, pop;

    // Arbiter state
    logic [ChanW-1:0] rr_ptr_q, gnt_q, gnt;
    logic             gnt_lock_q, found, req_fire;

    // Tag FIFO and in-flight accounting
    logic [ChanW-1:0]   tag_mem [MaxInFlight];
    logic [TagPtrW-1:0] tag_wptr_q, tag_rptr_q;
    logic [InfW-1:0]    inflight_q;
    logic [InfW-1:0]    chan_inf_q [NumChan];
    logic               rsp_fire;
    logic [ChanW-1:0]   rsp_chan;

    // Status
    logic [CntWidth-1:0] done_cnt_q [NumChan];
    logic [NumChan-1:0]  irq_q, err_q, irq_set, err_set;

    // FIFO flags and descriptor acceptance; zero-length descriptors are swallowed
    always_comb begin
        for (int c = 0; c < NumChan; c++) begin
            full[c]     = (cnt_q[c] == (PtrW+1)'(DescDepth));
            nonempty[c] = (cnt_q[c] != '0);
            len_zero[c] = (desc_len_i[c*LenWidth +: LenWidth] == '0);
        end
        desc_ready_o = ~full;
        accept       = desc_valid_i & ~full;
        push         = accept & ~len_zero;
    end

    // Round-robin grant; a pending grant is held so the payload stays stable under backpressure
    always_comb begin
        int idx;
        idx   = 0;
        gnt   = gnt_q;
        found = gnt_lock_q;
        if (!gnt_lock_q) begin
            found = 1'b0;
            gnt   = '0;
            for (int i = 0; i < NumChan; i++) begin
                idx = (int'(rr_ptr_q) + i) % int'(NumChan);
                if (!found && nonempty[idx]) begin
                    found = 1'b1;
                    gnt   = ChanW'(idx);
                end
            end
        end
        req_valid_o = found && (inflight_q < InfW'(MaxInFlight));
        req_fire    = req_valid_o && req_ready_i;
        for (int c = 0; c < NumChan; c++) begin
            pop[c] = req_fire && (gnt == ChanW'(c));
        end
        req_src_o  = src_mem[gnt][rptr_q[gnt]];
        req_dst_o  = dst_mem[gnt][rptr_q[gnt]];
        req_len_o  = len_mem[gnt][rptr_q[gnt]];
        req_chan_o = gnt;
    end

    // Response side: in-order tags, set vectors for irq/err
    always_comb begin
        rsp_ready_o = (inflight_q != '0);
        rsp_fire    = rsp_valid_i && rsp_ready_o;
        rsp_chan    = tag_mem[tag_rptr_q];
        for (int c = 0; c < NumChan; c++) begin
            irq_set[c] = rsp_fire && (rsp_chan == ChanW'(c));
        end
        err_set = (accept & len_zero) | (rsp_error_i ? irq_set : '0);
    end

    // Output packing and busy
    always_comb begin
        for (int c = 0; c < NumChan; c++) begin
            done_cnt_o[c*CntWidth +: CntWidth] = done_cnt_q[c];
            busy_o[c] = nonempty[c] || (chan_inf_q[c] != '0);
        end
        irq_o = irq_q;
        err_o = err_q;
    end

    // Descriptor FIFO payload write (no reset needed; validity lives in the counters)
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumChan; c++) begin
            if (push[c]) begin
                src_mem[c][wptr_q[c]] <= desc_src_i[c*AddrWidth +: AddrWidth];
                dst_mem[c][wptr_q[c]] <= desc_dst_i[c*AddrWidth +: AddrWidth];
                len_mem[c][wptr_q[c]] <= desc_len_i[c*LenWidth +: LenWidth];
            end
        end
    end

    // Descriptor FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumChan; c++) begin
            if (rst_i) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end else begin
                if (push[c]) wptr_q[c] <= wptr_q[c] + 1'b1;
                if (pop[c])  rptr_q[c] <= rptr_q[c] + 1'b1;
                cnt_q[c] <= cnt_q[c] + (PtrW+1)'(push[c]) - (PtrW+1)'(pop[c]);
            end
        end
    end

    // Arbiter pointer and grant lock
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            gnt_lock_q <= 1'b0;
        end else begin
            gnt_q <= gnt;
            if (req_fire) begin
                rr_ptr_q   <= (gnt == ChanW'(NumChan - 1)) ? '0 : gnt + 1'b1;
                gnt_lock_q <= 1'b0;
            end else begin
                gnt_lock_q <= req_valid_o;
            end
        end
    end

    // Tag FIFO write (storage only)
    always_ff @(posedge clk_i) begin
        if (req_fire) tag_mem[tag_wptr_q] <= gnt;
    end

    // Tag FIFO pointers and in-flight counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_wptr_q <= '0;
            tag_rptr_q <= '0;
            inflight_q <= '0;
            for (int c = 0; c < NumChan; c++) chan_inf_q[c] <= '0;
        end else begin
            if (req_fire) begin
                tag_wptr_q <= (tag_wptr_q == TagPtrW'(MaxInFlight - 1)) ? '0 : tag_wptr_q + 1'b1;
            end
            if (rsp_fire) begin
                tag_rptr_q <= (tag_rptr_q == TagPtrW'(MaxInFlight - 1)) ? '0 : tag_rptr_q + 1'b1;
            end
            inflight_q <= inflight_q + InfW'(req_fire) - InfW'(rsp_fire);
            for (int c = 0; c < NumChan; c++) begin
                chan_inf_q[c] <= chan_inf_q[c] + InfW'(pop[c]) - InfW'(irq_set[c]);
            end
        end
    end

    // Completion counters, interrupts and sticky errors; a set beats a coincident clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q <= '0;
            err_q <= '0;
            for (int c = 0; c < NumChan; c++) done_cnt_q[c] <= '0;
        end else begin
            irq_q <= (irq_q & ~irq_clr_i) | irq_set;
            err_q <= (err_q & ~err_clr_i) | err_set;
            for (int c = 0; c < NumChan; c++) begin
                if (irq_set[c]) done_cnt_q[c] <= done_cnt_q[c] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eth_idma_desc_arb.sv
// Directed bench for eth_idma_desc_arb with a queue-based reference model checked every cycle.
module tb_eth_idma_desc_arb;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } desc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  desc_valid = '0;
    logic [1:0]  desc_ready;
    logic [63:0] desc_src = '0, desc_dst = '0, desc_len = '0;
    logic        req_valid, req_ready = 1'b0;
    logic [31:0] req_src, req_dst, req_len;
    logic [0:0]  req_chan;
    logic        rsp_valid = 1'b0, rsp_ready, rsp_error = 1'b0;
    logic [15:0] done_cnt;
    logic [1:0]  irq, err, busy;
    logic [1:0]  irq_clr = '0, err_clr = '0;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    eth_idma_desc_arb dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .desc_valid_i (desc_valid),
        .desc_ready_o (desc_ready),
        .desc_src_i   (desc_src),
        .desc_dst_i   (desc_dst),
        .desc_len_i   (desc_len),
        .req_valid_o  (req_valid),
        .req_ready_i  (req_ready),
        .req_src_o    (req_src),
        .req_dst_o    (req_dst),
        .req_len_o    (req_len),
        .req_chan_o   (req_chan),
        .rsp_valid_i  (rsp_valid),
        .rsp_ready_o  (rsp_ready),
        .rsp_error_i  (rsp_error),
        .done_cnt_o   (done_cnt),
        .irq_o        (irq),
        .irq_clr_i    (irq_clr),
        .err_o        (err),
        .err_clr_i    (err_clr),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    desc_t mq [2][$];
    int    mtq [$];
    int    m_rr = 0;
    bit    m_hold = 1'b0;
    int    m_hold_chan = 0;
    int    m_done [2] = '{0, 0};
    logic [1:0] m_irq = '0, m_err = '0;

    function automatic bit exp_req_valid();
        return ((mq[0].size() > 0) || (mq[1].size() > 0)) && (mtq.size() < 4);
    endfunction

    function automatic int exp_chan();
        if (m_hold) return m_hold_chan;
        for (int i = 0; i < 2; i++) begin
            if (mq[(m_rr + i) % 2].size() > 0) return (m_rr + i) % 2;
        end
        return 0;
    endfunction

    function automatic int inflight_of(input int c);
        int n = 0;
        foreach (mtq[i]) if (mtq[i] == c) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        bit         v, rsp_acc;
        int         g, t;
        logic [1:0] acc, iset, eset;
        if (rst) begin
            mq[0].delete();
            mq[1].delete();
            mtq.delete();
            m_rr = 0;
            m_hold = 1'b0;
            m_done = '{0, 0};
            m_irq = '0;
            m_err = '0;
        end else begin
            iset = '0;
            eset = '0;
            v = exp_req_valid();
            g = exp_chan();
            rsp_acc = rsp_valid && (mtq.size() > 0);
            for (int c = 0; c < 2; c++) acc[c] = desc_valid[c] && (mq[c].size() < 4);
            if (rsp_acc) begin
                t = mtq.pop_front();
                m_done[t] = (m_done[t] + 1) % 256;
                iset[t] = 1'b1;
                if (rsp_error) eset[t] = 1'b1;
            end
            if (v && req_ready) begin
                void'(mq[g].pop_front());
                mtq.push_back(g);
                m_rr = (g + 1) % 2;
                m_hold = 1'b0;
            end else begin
                m_hold = v;
                m_hold_chan = g;
            end
            for (int c = 0; c < 2; c++) begin
                if (acc[c]) begin
                    if (desc_len[c*32 +: 32] == 0) eset[c] = 1'b1;
                    else mq[c].push_back('{desc_src[c*32 +: 32], desc_dst[c*32 +: 32],
                                          desc_len[c*32 +: 32]});
                end
            end
            m_irq = (m_irq & ~irq_clr) | iset;
            m_err = (m_err & ~err_clr) | eset;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        int    g;
        desc_t h;
        if (cmp_en) begin
            check("desc_ready", desc_ready, {mq[1].size() < 4, mq[0].size() < 4});
            check("req_valid", req_valid, exp_req_valid());
            check("rsp_ready", rsp_ready, mtq.size() > 0);
            check("done_cnt0", done_cnt[7:0], m_done[0]);
            check("done_cnt1", done_cnt[15:8], m_done[1]);
            check("irq", irq, m_irq);
            check("err", err, m_err);
            for (int c = 0; c < 2; c++) begin
                check("busy", busy[c], (mq[c].size() > 0) || (inflight_of(c) > 0));
            end
            if (exp_req_valid()) begin
                g = exp_chan();
                h = mq[g][0];
                check("req_chan", req_chan, g);
                check("req_src", req_src, h.src);
                check("req_dst", req_dst, h.dst);
                check("req_len", req_len, h.len);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_desc(input int c, input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] l);
        desc_valid[c] = 1'b1;
        desc_src[c*32 +: 32] = s;
        desc_dst[c*32 +: 32] = d;
        desc_len[c*32 +: 32] = l;
    endtask

    task automatic do_reset();
        desc_valid = '0;
        rsp_valid  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int seq [$];
    int cnt;

    initial begin
        @(posedge clk);
        #2;
        cmp_en = 1'b1;
        #3;
        check("rst_req_valid", req_valid, 0);
        check("rst_desc_ready", desc_ready, 2'b11);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Single descriptor through to completion
        req_ready = 1'b1;
        set_desc(0, 32'h1000, 32'h2000, 32'd64);
        #3;
        check("no_fallthrough", req_valid, 0);
        tick();
        desc_valid = '0;
        #3;
        check("t1_valid", req_valid, 1);
        check("t1_src", req_src, 32'h1000);
        check("t1_dst", req_dst, 32'h2000);
        check("t1_len", req_len, 64);
        check("t1_chan", req_chan, 0);
        tick();
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        #3;
        check("t1_done", done_cnt[7:0], 1);
        check("t1_irq", irq[0], 1);
        tick();
        irq_clr = 2'b01;
        tick();
        irq_clr = '0;

        // Round-robin 0,1,0,1,0,1
        do_reset();
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_desc(0, 32'h100 + i, 32'h1100 + i, i + 1);
            set_desc(1, 32'h200 + i, 32'h1200 + i, i + 5);
            tick();
        end
        desc_valid = '0;
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #3;
            if (req_valid && req_ready) seq.push_back(int'(req_chan));
            @(posedge clk);
            #2;
        end
        rsp_valid = 1'b0;
        check("rr_count", seq.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("rr_seq", (i < seq.size()) ? seq[i] : 99, i % 2);
        end

        // Backpressure stability, then the in-flight limit
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_desc(0, 32'hA000 + 16 * i, 32'hB000, 32'h40);
            set_desc(1, 32'hC000 + 16 * i, 32'hD000, 32'h80);
            tick();
        end
        desc_valid = '0;
        for (int k = 0; k < 5; k++) begin
            #3;
            check("bp_valid", req_valid, 1);
            check("bp_src", req_src, 32'hA000);
            check("bp_len", req_len, 32'h40);
            check("bp_chan", req_chan, 0);
            @(posedge clk);
            #2;
        end
        req_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            #3;
            if (req_valid && req_ready) cnt++;
            @(posedge clk);
            #2;
        end
        check("max_inflight_issued", cnt, 4);
        #3;
        check("fifth_req_low", req_valid, 0);
        check("busy_both", busy, 2'b11);
        @(posedge clk);
        #2;
        rsp_valid = 1'b1;
        repeat (10) tick();
        rsp_valid = 1'b0;

        // FIFO full on channel 1
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_desc(1, 32'hE000 + i, 32'hF000, 32'd8);
            #3;
            if (i == 4) check("full_ready", desc_ready[1], 0);
            @(posedge clk);
            #2;
        end
        desc_valid = '0;
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            #3;
            if (req_valid && req_ready && req_chan == 1'b1) cnt++;
            @(posedge clk);
            #2;
        end
        rsp_valid = 1'b0;
        check("full_issued", cnt, 4);

        // Zero length, set/clear collision, clear, response error
        set_desc(0, 32'h5000, 32'h6000, 32'd0);
        tick();
        desc_valid = '0;
        #3;
        check("len0_err", err[0], 1);
        check("len0_noreq", req_valid, 0);
        @(posedge clk);
        #2;
        set_desc(0, 32'h5000, 32'h6000, 32'd0);
        err_clr = 2'b01;
        tick();
        desc_valid = '0;
        err_clr = '0;
        #3;
        check("set_wins", err[0], 1);
        @(posedge clk);
        #2;
        err_clr = 2'b01;
        tick();
        err_clr = '0;
        #3;
        check("err_cleared", err[0], 0);
        @(posedge clk);
        #2;
        set_desc(1, 32'h7000, 32'h8000, 32'd8);
        tick();
        desc_valid = '0;
        tick();
        rsp_valid = 1'b1;
        rsp_error = 1'b1;
        tick();
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        #3;
        check("rsp_err", err[1], 1);
        check("rsp_irq", irq[1], 1);
        @(posedge clk);
        #2;
        irq_clr = 2'b11;
        err_clr = 2'b11;
        tick();
        irq_clr = '0;
        err_clr = '0;

        // 256 completions wrap the counter
        do_reset();
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        cnt = 0;
        set_desc(0, 32'h9000, 32'h9800, 32'd4);
        for (int k = 0; k < 400 && cnt < 256; k++) begin
            #3;
            if (desc_valid[0] && desc_ready[0]) cnt++;
            @(posedge clk);
            #2;
            if (cnt == 256) desc_valid = '0;
        end
        desc_valid = '0;
        repeat (10) tick();
        rsp_valid = 1'b0;
        #3;
        check("wrap_accepted", cnt, 256);
        check("wrap_done", done_cnt[7:0], 0);
        @(posedge clk);
        #2;

        // Reset with two requests in flight
        set_desc(0, 32'h1, 32'h2, 32'd16);
        set_desc(1, 32'h3, 32'h4, 32'd16);
        tick();
        desc_valid = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        #3;
        check("inrst_req_valid", req_valid, 0);
        check("inrst_rsp_ready", rsp_ready, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #3;
        check("post_req_valid", req_valid, 0);
        check("post_rsp_ready", rsp_ready, 0);
        check("post_busy", busy, 0);
        check("post_desc_ready", desc_ready, 2'b11);
        check("post_done", done_cnt, 0);
        check("post_irq", irq, 0);
        check("post_err", err, 0);
        for (int p = 0; p < 2; p++) begin
            @(posedge clk);
            #2;
            rsp_valid = 1'b1;
            #3;
            check("late_rsp_ready", rsp_ready, 0);
            @(posedge clk);
            #2;
            rsp_valid = 1'b0;
        end
        #3;
        check("late_done", done_cnt, 0);
        check("late_irq", irq, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
